// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: owns read/write pointers, status flags and
// access gating, and drives an external dual-port RAM that holds the data.
module fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    // producer / consumer side
    input  logic                          fifo_wr_en,
    input  logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_full,
    input  logic                          fifo_rd_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_out,
    output logic                          fifo_empty,
    output logic                          data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    // dual-port RAM side
    output logic                          ram_wr_en,
    output logic [$clog2(FIFO_DEPTH)-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]         ram_data_in,
    output logic                          ram_rd_en,
    output logic [$clog2(FIFO_DEPTH)-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         ram_data_out
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             acc_wr;
    logic             acc_rd;

    // Status derived purely from registered pointers; no input lookahead.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count      = PTR_W'(wr_ptr - rd_ptr);

    // Gate requests against the pre-operation flags: a full FIFO rejects a
    // write even when a read in the same cycle frees a slot, and an empty
    // FIFO never bypasses write data to the read side.
    assign acc_wr = fifo_wr_en && !fifo_full;
    assign acc_rd = fifo_rd_en && !fifo_empty;

    // RAM drive; the RAM registers read data, so data_out is a passthrough.
    assign ram_wr_en     = acc_wr;
    assign ram_wr_addr   = wr_ptr[ADDR_W-1:0];
    assign ram_data_in   = fifo_data_in;
    assign ram_rd_en     = acc_rd;
    assign ram_rd_addr   = rd_ptr[ADDR_W-1:0];
    assign fifo_data_out = ram_data_out;

    // Write pointer advances once per accepted write, wrapping naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
        end else if (acc_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer advances once per accepted read, wrapping naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
        end else if (acc_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // data_valid marks the cycle in which the RAM presents the read word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= acc_rd;
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that implements the FIFO side of fifo_if (modport fifo) for the system.
- Drives an external dual-port RAM through dp_ram_if (modport sys).
- Owns the read/write pointers, full/empty/count generation and access gating. Storage lives entirely in the downstream dp_ram block.
- Sits between any producer/consumer pair, e.g. a BIU data buffer and its RAM.

Parameters:
- DATA_WIDTH, 8, width of FIFO entries; must match the attached dp_ram_if DATA_WIDTH.
- FIFO_DEPTH, 8, number of entries; power of two and >= 2; must equal the attached dp_ram_if RAM_DEPTH.

Ports:
- clk  input  1  single clock for all logic
- n_rst  input  1  asynchronous active-low reset
- fifo.wr_en  input  1  write request from producer
- fifo.data_in  input  DATA_WIDTH  write data
- fifo.full  output  1  FIFO holds FIFO_DEPTH entries
- fifo.rd_en  input  1  read request from consumer
- fifo.data_out  output  DATA_WIDTH  read data; valid the cycle after an accepted read
- fifo.empty  output  1  FIFO holds 0 entries
- data_valid  output  1  high one cycle after each accepted read
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- ram.wr_en  output  1  RAM write strobe
- ram.wr_addr  output  $clog2(FIFO_DEPTH)  RAM write address
- ram.data_in  output  DATA_WIDTH  RAM write data
- ram.rd_en  output  1  RAM read strobe
- ram.rd_addr  output  $clog2(FIFO_DEPTH)  RAM read address
- ram.data_out  input  DATA_WIDTH  RAM read data, registered one cycle after rd_en

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are registered, $clog2(FIFO_DEPTH)+1 bits wide; the extra MSB is a wrap bit.
  - Both increment by 1 per accepted op, modulo 2*FIFO_DEPTH (natural wrap).
- Status flags (combinational from registered pointers, no input lookahead):
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ && low bits equal).
  - count = wr_ptr - rd_ptr, modulo 2^width.
- Accepted write: acc_wr = wr_en && !full. Accepted read: acc_rd = rd_en && !empty.
- RAM drive:
  - ram.wr_en = acc_wr; ram.wr_addr = wr_ptr low bits; ram.data_in = fifo.data_in.
  - ram.rd_en = acc_rd; ram.rd_addr = rd_ptr low bits.
  - fifo.data_out = ram.data_out, passthrough; the RAM holds its last read value.
- data_valid: register set to acc_rd each cycle, so it is high the cycle after an accepted read. Read latency = 1 cycle.
- Overflow and underflow:
  - wr_en while full: ignored. No RAM write, wr_ptr unchanged, no error flag.
  - rd_en while empty: ignored. No RAM read, rd_ptr unchanged, data_valid low next cycle.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted; count unchanged; both pointers advance.
  - Full: read accepted, write rejected, because full is sampled before the read frees a slot. Next cycle count = FIFO_DEPTH-1.
  - Empty: write accepted, read rejected (no bypass). Next cycle empty = 0, count = 1.
- Same-address read/write: cannot occur, because a read is only accepted when count >= 1 and a write only when count <= FIFO_DEPTH-1.
- Wrap-around: low bits roll from FIFO_DEPTH-1 to 0 and the MSB toggles. The full/empty distinction relies solely on the MSB.
- Reset (async assert, release synchronised externally):
  - wr_ptr = rd_ptr = 0, data_valid = 0, so empty = 1, full = 0, count = 0, ram.wr_en = ram.rd_en = 0.
  - Reset mid-operation discards all contents immediately; an in-flight read produces no data_valid.
  - RAM contents are not cleared and are treated as undefined.

Test Plan:
- Reset: assert n_rst low mid-stream with count = 5 -> immediately empty = 1, full = 0, count = 0, data_valid = 0; first write after release lands at ram.wr_addr = 0.
- Fill/drain: write 0x01..0x08 on consecutive cycles -> full = 1 after the 8th, count = 8. Read 8 times -> data_out 0x01..0x08 each with data_valid on the following cycle, then empty = 1.
- Overflow/underflow: wr_en with data 0xAA while full -> ram.wr_en = 0, count stays 8. rd_en while empty -> ram.rd_en = 0, data_valid = 0 next cycle.
- Simultaneous ops:
  - wr_en and rd_en at count = 4 -> count stays 4, both addresses advance.
  - Same at full -> count = 7, write dropped.
  - Same at empty -> count = 1, read dropped.
- Wrap-around: stream 20 writes interleaved with reads at count around 3 -> addresses wrap 7 -> 0 at least twice, data order preserved, full/empty never asserted spuriously.
